// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a core built without internal
// memory. Word RAM at address 0, plus a 16-byte MMIO page holding a console
// TX FIFO, a free-running cycle counter, a dropped-byte counter and a sticky
// TOHOST halt/exit register.
//
// MMIO page map (offset from MMIO_BASE)
//   +0x0  read: STATUS {30'b0, fifo_full, fifo_empty}   write: console push
//   +0x4  read: CYCLE                                   write: CYCLE load
//   +0x8  read: EXIT_CODE                               write: TOHOST
//   +0xC  read: DROPS                                   write: ignored
module dmem_responder #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [31:0] DMEM_ARADDR,
  output logic [31:0] DMEM_RDATA,
  input  logic [31:0] DMEM_AWADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic        DMEM_AWVALID,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        HALT,
  output logic [31:0] EXIT_CODE
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OFS_CONSOLE = 2'd0;
  localparam logic [1:0] OFS_CYCLE   = 2'd1;
  localparam logic [1:0] OFS_TOHOST  = 2'd2;
  localparam logic [1:0] OFS_DROPS   = 2'd3;

  localparam logic [FW:0] FIFO_FULL_CNT = (FW+1)'(FIFO_DEPTH);

  // Byte-lane bits of both addresses are don't-care for a word-only interface.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{DMEM_ARADDR[1:0], DMEM_AWADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic rd_ram_hit;
  logic rd_mmio_hit;
  logic wr_ram_hit;
  logic wr_mmio_hit;

  assign rd_ram_hit  = (DMEM_ARADDR[31:AW+2] == '0);
  assign rd_mmio_hit = (DMEM_ARADDR[31:4] == MMIO_BASE[31:4]);
  assign wr_ram_hit  = (DMEM_AWADDR[31:AW+2] == '0);
  assign wr_mmio_hit = (DMEM_AWADDR[31:4] == MMIO_BASE[31:4]);

  // RAM takes priority so an overlapping MMIO_BASE can never shadow memory.
  logic ram_we;
  logic wr_console;
  logic wr_cycle;
  logic wr_tohost;

  assign ram_we     = DMEM_AWVALID & wr_ram_hit;
  assign wr_console = DMEM_AWVALID & ~wr_ram_hit & wr_mmio_hit & (DMEM_AWADDR[3:2] == OFS_CONSOLE);
  assign wr_cycle   = DMEM_AWVALID & ~wr_ram_hit & wr_mmio_hit & (DMEM_AWADDR[3:2] == OFS_CYCLE);
  assign wr_tohost  = DMEM_AWVALID & ~wr_ram_hit & wr_mmio_hit & (DMEM_AWADDR[3:2] == OFS_TOHOST);

  // ---------------------------------------------------------------------------
  // Word RAM (deliberately not reset: contents survive a mid-run reset)
  // ---------------------------------------------------------------------------
  logic [31:0] ram [DEPTH];

  // Commit RAM writes at the edge; reads in the same cycle still see old data.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[DMEM_AWADDR[AW+1:2]] <= DMEM_WDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Console TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [FW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Full/empty come from the registered count only, so a pop on the same edge
  // never makes room for a push that arrived while full.
  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = wr_console & ~fifo_full;
  assign pop        = ~fifo_empty & TX_READY;

  // FIFO storage needs no reset; TX_DATA is gated while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= DMEM_WDATA[7:0];
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign TX_VALID = ~fifo_empty;
  assign TX_DATA  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Counters and TOHOST
  // ---------------------------------------------------------------------------
  logic [31:0] cycle;
  logic [31:0] drops;

  // Free-running cycle counter; a load replaces that edge's increment.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      cycle <= '0;
    end else if (wr_cycle) begin
      cycle <= DMEM_WDATA;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // Count console bytes rejected because the FIFO was full; saturates.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      drops <= '0;
    end else if (wr_console && fifo_full && (drops != 32'hFFFF_FFFF)) begin
      drops <= drops + 32'd1;
    end
  end

  // Sticky halt flag; every TOHOST write refreshes the exit code.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      HALT      <= 1'b0;
      EXIT_CODE <= '0;
    end else if (wr_tohost) begin
      HALT      <= 1'b1;
      EXIT_CODE <= DMEM_WDATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (zero latency)
  // ---------------------------------------------------------------------------

  // Select RAM word, MMIO register or zero for unmapped addresses.
  always_comb begin
    DMEM_RDATA = 32'h0000_0000;
    if (rd_ram_hit) begin
      DMEM_RDATA = ram[DMEM_ARADDR[AW+1:2]];
    end else if (rd_mmio_hit) begin
      case (DMEM_ARADDR[3:2])
        OFS_CONSOLE: DMEM_RDATA = {30'b0, fifo_full, fifo_empty};
        OFS_CYCLE:   DMEM_RDATA = cycle;
        OFS_TOHOST:  DMEM_RDATA = EXIT_CODE;
        OFS_DROPS:   DMEM_RDATA = drops;
        default:     DMEM_RDATA = 32'h0000_0000;
      endcase
    end
  end

endmodule
